// File: rtl/hilo_pkg.sv
// hilo_pkg: op codes, FSM encoding and counter sizing for the HI/LO mul/div unit
package hilo_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction
endpackage

// File: rtl/hilo_muldiv_unit_div_step.sv
// div_step: STEPS restoring-division iterations on unsigned magnitudes
module div_step #(
  parameter int DATA_W = 32,
  parameter int STEPS  = 1
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);
  logic [DATA_W:0] t;
  always_comb begin
    rem_o = rem_i;
    quo_o = quo_i;
    t = '0;
    for (int s = 0; s < STEPS; s++) begin
      t = {rem_o, quo_o[DATA_W-1]};
      quo_o = {quo_o[DATA_W-2:0], t >= {1'b0, div_i}};
      t = quo_o[0] ? t - {1'b0, div_i} : t;
      rem_o = t[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register pair with single-cycle multiply and iterative divide
module hilo_muldiv_unit import hilo_pkg::*; #(
  parameter int DATA_W    = 32,
  parameter int DIV_STEPS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int K  = DATA_W / DIV_STEPS;
  localparam int CW = cnt_w(K);
  localparam logic [CW-1:0] CNT_INIT = CW'(K - 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
  logic [DATA_W-1:0] rem_n, quo_n;
  logic [2*DATA_W-1:0] prod;
  logic accept, is_signed, a_neg, b_neg;
  assign op_ready  = state_q == S_IDLE;
  assign busy      = ~op_ready;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign accept    = op_valid & op_ready & ~flush;
  assign is_signed = op_code == OP_MULT || op_code == OP_DIV;
  assign a_neg     = is_signed & src_a[DATA_W-1];
  assign b_neg     = is_signed & src_b[DATA_W-1];
  // extending both operands to 2*DATA_W lets one unsigned multiplier serve MULT and MULTU
  assign prod = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q} * {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
  div_step #(.DATA_W(DATA_W), .STEPS(DIV_STEPS)) u_div_step (
    .rem_i(rem_q),
    .quo_i(a_q),
    .div_i(b_q),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept && op_code == OP_MTHI) hi_d = src_a;
      if (accept && op_code == OP_MTLO) lo_d = src_a;
      if (accept && (op_code == OP_MULT || op_code == OP_MULTU)) begin
        state_d = S_MUL;
        a_d     = src_a;
        b_d     = src_b;
        sgn_d   = op_code == OP_MULT;
      end
      if (accept && (op_code == OP_DIV || op_code == OP_DIVU)) begin
        state_d = S_DIV;
        cnt_d   = CNT_INIT;
        rem_d   = '0;
        a_d     = a_neg ? -src_a : src_a;
        b_d     = b_neg ? -src_b : src_b;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = src_b == '0;
      end
    end else if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_MUL) begin
      {hi_d, lo_d} = prod;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else if (state_q == S_DIV) begin
      rem_d   = rem_n;
      a_d     = quo_n;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      state_d = cnt_q == '0 ? S_FIX : S_DIV;
    end else begin
      // a zero divisor leaves the dividend magnitude in rem, so the sign fix restores src_a
      lo_d    = dz_q ? '1 : (qneg_q ? -a_q : a_q);
      hi_d    = rneg_q ? -rem_q : rem_q;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench with an arithmetic reference model
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  localparam int STEPS = 1;
  localparam int K = W / STEPS;
  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int due;
  } exp_t;
  logic clk, rst, op_valid, op_ready, flush, busy, done;
  logic [2:0] op_code;
  logic [W-1:0] src_a, src_b, hi, lo;
  logic [W-1:0] mhi, mlo;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  hilo_muldiv_unit #(.DATA_W(W), .DIV_STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint p;
    h = mhi;
    l = mlo;
    if (op == 3'd0) begin
      p = longint'($signed(a)) * longint'($signed(b));
      {h, l} = p;
    end else if (op == 3'd1) begin
      p = longint'({32'b0, a}) * longint'({32'b0, b});
      {h, l} = p;
    end else if ((op == 3'd2 || op == 3'd3) && b == 0) begin
      l = '1;
      h = a;
    end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      l = a;
      h = '0;
    end else if (op == 3'd2) begin
      l = $signed(a) / $signed(b);
      h = $signed(a) % $signed(b);
    end else if (op == 3'd3) begin
      l = a / b;
      h = a % b;
    end else if (op == 3'd4) h = a;
    else if (op == 3'd5) l = a;
  endfunction
  // monitor: every done pulse must match the oldest outstanding result, on time
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        e = sb.pop_front();
        chk("done_hi", 64'(hi), 64'(e.hi));
        chk("done_lo", 64'(lo), 64'(e.lo));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int n = 0;
    exp_t e;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ready_timeout", 64'(op_ready), 64'd1);
    op_valid = 1'b1;
    op_code = op;
    src_a = a;
    src_b = b;
    if (track) begin
      model(op, a, b, e.hi, e.lo);
      mhi = e.hi;
      mlo = e.lo;
      e.due = cyc + 1 + (op < 3'd2 ? 1 : K + 1);
      if (op < 3'd4) sb.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
    op_code = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    if (track && op >= 3'd4) begin
      chk("mtx_hi", 64'(hi), 64'(mhi));
      chk("mtx_lo", 64'(lo), 64'(mlo));
      chk("mtx_ready", 64'(op_ready), 64'd1);
    end
  endtask
  function automatic logic [W-1:0] rnd_val();
    int s = $urandom_range(0, 5);
    return s == 0 ? '0 : s == 1 ? '1 : s == 2 ? 32'h8000_0000 :
           s == 3 ? W'($urandom_range(0, 20)) : s == 4 ? -W'($urandom_range(1, 20)) : W'($urandom);
  endfunction
  initial begin
    int n;
    mhi = '0;
    mlo = '0;
    rst = 1'b1;
    op_valid = 1'b0;
    flush = 1'b0;
    op_code = '0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    issue(3'd0, -32'sd3, 32'd5, 1);
    chk("mul_expected_hi", 64'(mhi), 64'hffff_ffff);
    issue(3'd3, 32'd100, 32'd7, 1);
    n = 1;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("divu_busy_cycles", 64'(n - 1), 64'(K + 1));
    issue(3'd2, -32'sd7, 32'd2, 1);
    issue(3'd2, 32'h8000_0000, 32'hffff_ffff, 1);
    issue(3'd3, 32'h1234, 32'd0, 1);
    issue(3'd2, -32'sd1234, 32'd0, 1);
    issue(3'd1, 32'hffff_ffff, 32'hffff_ffff, 1);
    issue(3'd4, 32'ha5a5_a5a5, '0, 1);
    issue(3'd5, 32'h5a5a_5a5a, '0, 1);
    chk("mthi_kept", 64'(hi), 64'ha5a5_a5a5);
    issue(3'd4, 32'd1, '0, 1);
    issue(3'd5, 32'd2, '0, 1);
    issue(3'd3, 32'd50, 32'd3, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 64'(op_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_hi", 64'(hi), 64'd1);
    chk("flush_lo", 64'(lo), 64'd2);
    op_valid = 1'b1;
    flush = 1'b1;
    op_code = 3'd4;
    src_a = 32'hdead_beef;
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_hi", 64'(hi), 64'd1);
    issue(3'd3, 32'd100, 32'd7, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mhi = '0;
    mlo = '0;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_ready", 64'(op_ready), 64'd1);
    issue(3'd0, 32'd12345, -32'sd678, 1);
    for (int i = 0; i < 300; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    chk("final_hi", 64'(hi), 64'(mhi));
    chk("final_lo", 64'(lo), 64'(mlo));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
